wb_burst_ram: RTL

Parametrised Wishbone B4 registered-feedback slave RAM, successor to the single-word SoC RAM.
- Configurable data width and depth; byte-lane writes with no read-modify-write.
- Incrementing and wrapping bursts (CTI/BTE) at one beat per clock.
- Error response for out-of-range addresses.
- Sits on the SoC Wishbone interconnect as program/data memory for the CPU and DMA masters.

---
 rtl/wb_pkg.sv | 38 +++
 rtl/ram_bytelane_sdp.sv | 44 ++++
 rtl/wb_burst_ram.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone B4 registered-feedback definitions: cycle type (CTI) and
// burst type (BTE) encodings, the slave state type and the burst address
// sequencer used by burst-capable slaves.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wb_state_e;

    // Address of the beat following 'adr' (word addresses). Linear bursts
    // simply increment; wrapN bursts increment the low log2(N) bits modulo N
    // and hold the upper bits, so the burst stays in its aligned N-word block.
    function automatic logic [31:0] wb_next_adr(input logic [31:0] adr,
                                                input logic [1:0]  bte);
        logic [31:0] inc;
        inc = adr + 32'd1;
        case (bte)
            BTE_WRAP4:  return {adr[31:2], inc[1:0]};
            BTE_WRAP8:  return {adr[31:3], inc[2:0]};
            BTE_WRAP16: return {adr[31:4], inc[3:0]};
            default:    return inc;
        endcase
    endfunction

endpackage

// File: rtl/ram_bytelane_sdp.sv
// ---------------------------------------------------------------------------
// ram_bytelane_sdp
// Simple dual-port RAM with registered read and per-byte write enables.
// Each byte lane is its own array so a partial write never needs a
// read-modify-write.
//   clk     in   clock, rising edge
//   rd_adr  in   read word address (data appears one clock later)
//   rd_dat  out  registered read data
//   wr_adr  in   write word address
//   wr_dat  in   write data
//   wr_be   in   per-byte write enables
// ---------------------------------------------------------------------------
module ram_bytelane_sdp #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rd_adr,
    output logic [DATA_WIDTH-1:0] rd_dat,
    input  logic [ADDR_WIDTH-1:0] wr_adr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [SEL_WIDTH-1:0]  wr_be
);

    genvar gi;
    generate
        for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    lane_mem[wr_adr] <= wr_dat[gi*8 +: 8];
                end
                lane_rd_q <= lane_mem[rd_adr];
            end

            assign rd_dat[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/wb_burst_ram.sv
// ---------------------------------------------------------------------------
// wb_burst_ram
// Wishbone B4 registered-feedback slave RAM with byte-lane writes, linear and
// wrapping bursts at one beat per clock, and an error response for word
// addresses at or beyond WORD_COUNT.
//   clk_i       in   system clock, rising edge
//   rst_ni      in   asynchronous active-low reset
//   wb_dat_i    in   write data
//   wb_dat_o    out  read data, valid while wb_ack_o=1
//   wb_adr_i    in   word address (byte address bits [31:ADR_LSB])
//   wb_we_i     in   write enable
//   wb_sel_i    in   byte lane selects
//   wb_cyc_i    in   bus cycle
//   wb_stb_i    in   strobe
//   wb_cti_i    in   cycle type
//   wb_bte_i    in   burst type
//   wb_ack_o    out  acknowledge
//   wb_err_o    out  error (out-of-range address)
//   wb_stall_o  out  always 0
// ---------------------------------------------------------------------------
module wb_burst_ram
    import wb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int WORD_COUNT = 1024,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8,
    localparam int ADR_LSB    = $clog2(SEL_WIDTH),
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [31:ADR_LSB]     wb_adr_i,
    input  logic                  wb_we_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o
);

    wb_state_e            state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          adr_in;
    logic [31:0]          next_adr;
    logic [31:0]          rd_adr;
    logic                 rd_in_range;
    logic                 req;
    logic [SEL_WIDTH-1:0] wr_be;

    assign adr_in   = {{ADR_LSB{1'b0}}, wb_adr_i};
    assign next_adr = wb_next_adr(adr_q, wb_bte_i);
    assign req      = wb_cyc_i & wb_stb_i;

    // The address being read this cycle is also the address the next beat
    // will use, so a single range check serves both the IDLE request and the
    // burst continuation.
    assign rd_adr      = (state_q == ST_IDLE) ? adr_in : next_adr;
    assign rd_in_range = (rd_adr < 32'(WORD_COUNT));

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        adr_d   = adr_q;
        wr_be   = '0;
        case (state_q)
            ST_IDLE: begin
                // While err is showing the master still holds stb for the
                // terminating edge; ignore it so err lasts one cycle.
                if (req && !err_q) begin
                    adr_d = adr_in;
                    if (rd_in_range) begin
                        ack_d   = 1'b1;
                        state_d = ST_BURST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (req && ack_q) begin
                    if (wb_we_i) begin
                        wr_be = wb_sel_i;
                    end
                    if (wb_cti_i == CTI_INCR) begin
                        if (rd_in_range) begin
                            adr_d = next_adr;
                            ack_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // classic, end-of-burst and reserved cycle types
                        state_d = ST_IDLE;
                    end
                end else begin
                    // cyc dropped or master wait: abandon the burst
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
        end
    end

    ram_bytelane_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WORD_COUNT)
    ) u_ram (
        .clk    (clk_i),
        .rd_adr (rd_adr[ADDR_WIDTH-1:0]),
        .rd_dat (wb_dat_o),
        .wr_adr (adr_q[ADDR_WIDTH-1:0]),
        .wr_dat (wb_dat_i),
        .wr_be  (wr_be)
    );

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = 1'b0;

endmodule
